// File: rtl/cfar_threshold_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cfar_threshold_gen
//  Purpose  : Sliding-window CFAR threshold generator. Holds a window of
//             L = 2N + 2G + 1 magnitude samples, keeps running sums of the
//             leading and lagging reference cells, and emits the cell under
//             test together with a scaled, saturated detection threshold.
//  Options  : CFAR_GO_EN defined   -> greatest-of CFAR (max of the two sides)
//             CFAR_GO_EN undefined -> cell-averaging CFAR (mean of both sides)
//  Ports    : iCLK  - clock, rising edge
//             iRST  - asynchronous active-high reset
//             iEN   - sample strobe, iDATA/iK accepted when high
//             iCLR  - synchronous frame restart (empties the window)
//             iDATA - magnitude sample, IL bits unsigned
//             iK    - threshold scale factor, KW bits, 3 fractional bits
//             oDATA - cell under test aligned with oTH
//             oTH   - threshold for oDATA, saturated to 2^IL-1
//             oEN   - one-cycle strobe marking valid oDATA/oTH
//  Revision : 1.0 - initial release
// ============================================================================
module cfar_threshold_gen #(
    parameter int IL    = 10,
    parameter int LOG2N = 3,
    parameter int G     = 2,
    parameter int KW    = 6
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEN,
    input  logic          iCLR,
    input  logic [IL-1:0] iDATA,
    input  logic [KW-1:0] iK,
    output logic [IL-1:0] oDATA,
    output logic [IL-1:0] oTH,
    output logic          oEN
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_N   = 1 << LOG2N;          // reference cells per side
    localparam int c_L   = 2 * c_N + 2 * G + 1; // window length
    localparam int c_CUT = c_N + G;             // cell-under-test position
    localparam int c_KF  = 3;                   // fractional bits of iK
    localparam int c_SW  = IL + LOG2N;          // one-side sum width
    localparam int c_RW  = c_SW + 1;            // reference path width
    localparam int c_PW  = c_RW + KW;           // product width
    localparam int c_FW  = $clog2(c_L + 1);     // fill counter width

    localparam logic [c_FW-1:0] c_FULL  = c_FW'(c_L);
    localparam logic [c_PW-1:0] c_THMAX = {{(c_PW - IL){1'b0}}, {IL{1'b1}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IL-1:0]   r_win [c_L];   // index 0 = newest, c_L-1 = oldest
    logic [c_SW-1:0] r_sumLead;     // sum of positions 0 .. N-1
    logic [c_SW-1:0] r_sumLag;      // sum of positions N+2G+1 .. L-1
    logic [c_FW-1:0] r_fill;        // accepted samples this frame, saturates at L
    logic [IL-1:0]   r_outData;
    logic [IL-1:0]   r_outTh;
    logic            r_outEn;

    // ------------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------------
    logic            w_accept;
    logic [c_FW-1:0] w_fillNext;
    logic [c_SW-1:0] w_sumLeadNext;
    logic [c_SW-1:0] w_sumLagNext;
    logic [c_RW-1:0] w_refLevel;
    logic [c_PW-1:0] w_product;
    logic [c_PW-1:0] w_scaled;
    logic [IL-1:0]   w_threshold;

    // A clear takes priority; a sample arriving with the clear is handled
    // inside the clear branch as the first sample of the new frame.
    assign w_accept   = iEN & ~iCLR;
    assign w_fillNext = (r_fill == c_FULL) ? r_fill : r_fill + c_FW'(1);

    // Incremental sums. On a shift the cell at N-1 moves into the guard zone
    // and the cell at N+2G moves from the guard zone into the lagging side.
    // The modular arithmetic is exact because the result always fits.
    assign w_sumLeadNext = r_sumLead
                         + {{LOG2N{1'b0}}, iDATA}
                         - {{LOG2N{1'b0}}, r_win[c_N-1]};
    assign w_sumLagNext  = r_sumLag
                         + {{LOG2N{1'b0}}, r_win[c_N+2*G]}
                         - {{LOG2N{1'b0}}, r_win[c_L-1]};

`ifdef CFAR_GO_EN
    // Greatest-of: mean of the larger reference side.
    logic [c_SW-1:0] w_sumMax;
    assign w_sumMax   = (w_sumLeadNext > w_sumLagNext) ? w_sumLeadNext : w_sumLagNext;
    assign w_refLevel = {1'b0, w_sumMax} >> LOG2N;
`else
    // Cell-averaging: mean of all 2N reference cells, truncated.
    logic [c_RW-1:0] w_sumBoth;
    assign w_sumBoth  = {1'b0, w_sumLeadNext} + {1'b0, w_sumLagNext};
    assign w_refLevel = w_sumBoth >> (LOG2N + 1);
`endif

    // Full-width scale, drop the fractional bits, then clamp to IL bits.
    assign w_product   = {{KW{1'b0}}, w_refLevel} * {{c_RW{1'b0}}, iK};
    assign w_scaled    = w_product >> c_KF;
    assign w_threshold = (w_scaled > c_THMAX) ? {IL{1'b1}} : w_scaled[IL-1:0];

    // ------------------------------------------------------------------------
    // Window shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int p = 0; p < c_L; p++) begin
                r_win[p] <= '0;
            end
        end else if (iCLR) begin
            for (int p = 1; p < c_L; p++) begin
                r_win[p] <= '0;
            end
            r_win[0] <= iEN ? iDATA : '0;
        end else if (iEN) begin
            for (int p = 1; p < c_L; p++) begin
                r_win[p] <= r_win[p-1];
            end
            r_win[0] <= iDATA;
        end
    end

    // ------------------------------------------------------------------------
    // Running sums and fill counter
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sumLead <= '0;
            r_sumLag  <= '0;
            r_fill    <= '0;
        end else if (iCLR) begin
            // The new frame's first sample lands at position 0, a leading cell.
            r_sumLead <= iEN ? {{LOG2N{1'b0}}, iDATA} : '0;
            r_sumLag  <= '0;
            r_fill    <= iEN ? c_FW'(1) : '0;
        end else if (w_accept) begin
            r_sumLead <= w_sumLeadNext;
            r_sumLag  <= w_sumLagNext;
            r_fill    <= w_fillNext;
        end
    end

    // ------------------------------------------------------------------------
    // Output register: one cycle after an accepted sample that leaves the
    // window full. The new CUT is the cell currently one position younger.
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_outEn   <= 1'b0;
            r_outData <= '0;
            r_outTh   <= '0;
        end else begin
            r_outEn <= 1'b0;
            if (w_accept && (w_fillNext == c_FULL)) begin
                r_outEn   <= 1'b1;
                r_outData <= r_win[c_CUT-1];
                r_outTh   <= w_threshold;
            end
        end
    end

    assign oEN   = r_outEn;
    assign oDATA = r_outData;
    assign oTH   = r_outTh;

endmodule
`default_nettype wire

// File: tb/tb_cfar_threshold_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfar_threshold_gen
//  Purpose  : Self-checking bench for cfar_threshold_gen. A queue-based
//             reference model predicts oEN/oDATA/oTH every cycle; directed
//             phases add literal expectations, then a randomized phase runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cfar_threshold_gen;

    localparam int IL    = 10;
    localparam int LOG2N = 3;
    localparam int G     = 2;
    localparam int KW    = 6;
    localparam int N     = 1 << LOG2N;
    localparam int L     = 2 * N + 2 * G + 1;
    localparam int CUT   = N + G;
    localparam int THMAX = (1 << IL) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [IL-1:0] din = '0;
    logic [KW-1:0] k   = '0;
    logic [IL-1:0] oDATA;
    logic [IL-1:0] oTH;
    logic          oEN;

    cfar_threshold_gen #(
        .IL    (IL),
        .LOG2N (LOG2N),
        .G     (G),
        .KW    (KW)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .iEN   (en),
        .iCLR  (clr),
        .iDATA (din),
        .iK    (k),
        .oDATA (oDATA),
        .oTH   (oTH),
        .oEN   (oEN)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    bit chkOn  = 1'b0;

    // ------------------------------------------------------------------------
    // Reference model: the frame is a queue of samples, newest at the front.
    // ------------------------------------------------------------------------
    int            win[$];
    logic          expEn   = 1'b0;
    logic [IL-1:0] expData = '0;
    logic [IL-1:0] expTh   = '0;
    int            sl, sg, rl, th;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win.delete();
            expEn   <= 1'b0;
            expData <= '0;
            expTh   <= '0;
        end else begin
            expEn <= 1'b0;
            if (clr) begin
                win.delete();
                if (en) win.push_front(int'(din));
            end else if (en) begin
                win.push_front(int'(din));
                if (win.size() > L) void'(win.pop_back());
                if (win.size() == L) begin
                    sl = 0;
                    for (int i = 0; i < N; i++) sl += win[i];
                    sg = 0;
                    for (int i = N + 2 * G + 1; i < L; i++) sg += win[i];
`ifdef CFAR_GO_EN
                    rl = ((sl > sg) ? sl : sg) / N;
`else
                    rl = (sl + sg) / (2 * N);
`endif
                    th = (rl * int'(k)) / 8;
                    if (th > THMAX) th = THMAX;
                    expEn   <= 1'b1;
                    expData <= IL'(win[CUT]);
                    expTh   <= IL'(th);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Cycle-by-cycle comparison on the falling edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (chkOn) begin
            nTests++;
            if (oEN !== expEn) begin
                nFail++;
                $display("FAIL model_oEN t=%0t actual=%0b required=%0b", $time, oEN, expEn);
            end
            nTests++;
            if (oDATA !== expData) begin
                nFail++;
                $display("FAIL model_oDATA t=%0t actual=%0d required=%0d", $time, oDATA, expData);
            end
            nTests++;
            if (oTH !== expTh) begin
                nFail++;
                $display("FAIL model_oTH t=%0t actual=%0d required=%0d", $time, oTH, expTh);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, return just after the capturing edge.
    task automatic send(input bit e, input bit c, input int d, input int kk);
        @(negedge clk);
        en  = e;
        clr = c;
        din = IL'(d);
        k   = KW'(kk);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chkOn = 1'b1;
        #1;
        lit("reset_oEN", 32'(oEN), 0);
        lit("reset_oDATA", 32'(oDATA), 0);
        lit("reset_oTH", 32'(oTH), 0);
        @(negedge clk);
        rst = 1'b0;

        // Constant 100, K = 1.0, back-to-back
        for (int i = 0; i < 25; i++) begin
            send(1, 0, 100, 8);
            if (i == L - 2) lit("warmup_no_oEN", 32'(oEN), 0);
            if (i >= L - 1) begin
                lit("const_oEN", 32'(oEN), 1);
                lit("const_oDATA", 32'(oDATA), 100);
                lit("const_oTH", 32'(oTH), 100);
            end
        end

        // Clear alone, then constant 400 with K = 3.0 -> saturation
        send(0, 1, 0, 8);
        lit("clear_oEN", 32'(oEN), 0);
        for (int i = 0; i < L; i++) begin
            send(1, 0, 400, 24);
            if (i == L - 2) lit("clr_warmup_no_oEN", 32'(oEN), 0);
        end
        lit("sat_oEN", 32'(oEN), 1);
        lit("sat_oDATA", 32'(oDATA), 400);
        lit("sat_oTH", 32'(oTH), THMAX);

        // Clear with sample, background 50 and a single 900 spike at sample 30
        for (int i = 1; i <= 45; i++) begin
            send(1, (i == 1), (i == 30) ? 900 : 50, 16);
            if (i == 1)  lit("clren_oEN", 32'(oEN), 0);
            if (i == 20) lit("clren_warmup_no_oEN", 32'(oEN), 0);
            if (i == 21) lit("clren_first_oEN", 32'(oEN), 1);
            if (i == 40) begin
                lit("spike_oEN", 32'(oEN), 1);
                lit("spike_oDATA", 32'(oDATA), 900);
                lit("spike_oTH", 32'(oTH), 100);
            end
        end

        // iEN every third cycle: same values, strobes spaced out
        send(0, 1, 0, 8);
        for (int i = 0; i < 24; i++) begin
            send(1, 0, 100, 8);
            if (i >= L - 1) begin
                lit("gap_oDATA", 32'(oDATA), 100);
                lit("gap_oTH", 32'(oTH), 100);
            end
            send(0, 0, 7, 8);
            lit("gap_idle_oEN", 32'(oEN), 0);
            send(0, 0, 900, 63);
        end

        // Step: 8 x 200 then 13 x 100 (lagging 200, leading 100)
        send(0, 1, 0, 8);
        for (int i = 0; i < L; i++) send(1, 0, (i < 8) ? 200 : 100, 8);
        lit("step_oDATA", 32'(oDATA), 100);
`ifdef CFAR_GO_EN
        lit("step_oTH", 32'(oTH), 200);
`else
        lit("step_oTH", 32'(oTH), 150);
`endif

        // Asynchronous reset mid-frame
        for (int i = 0; i < 25; i++) send(1, 0, $urandom_range(0, THMAX), $urandom_range(0, 63));
        send(0, 0, 0, 8);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        lit("async_rst_oEN", 32'(oEN), 0);
        lit("async_rst_oDATA", 32'(oDATA), 0);
        lit("async_rst_oTH", 32'(oTH), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            send(1, 0, 300, 8);
            if (i == L - 2) lit("rst_warmup_no_oEN", 32'(oEN), 0);
        end
        lit("rst_first_oEN", 32'(oEN), 1);
        lit("rst_first_oTH", 32'(oTH), 300);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            send($urandom_range(0, 2) != 0,
                 $urandom_range(0, 59) == 0,
                 ($urandom_range(0, 7) == 0) ? THMAX : $urandom_range(0, THMAX),
                 $urandom_range(0, 63));
        end

        send(0, 0, 0, 8);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
